// File: rtl/cla_seq_pkg.sv
// Shared definitions for the slice-serial carry-lookahead adder.
package cla_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/CLA4.sv
// Single N-bit carry-lookahead slice with group propagate/generate outputs.
module CLA4 #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Pout,
  output logic         Gout
);

  // NOTE: combinational blocks use blocking '=' so each carry sees the one just computed;
  // the recurrence flattens into two-level lookahead terms at synthesis.
  always_comb begin
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;
    logic         gg;
    g    = A & B;
    p    = A ^ B;
    c    = '0;
    c[0] = Cin;
    gg   = 1'b0;
    for (int i = 0; i < N; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
      gg     = g[i] | (p[i] & gg);
    end
    Sum  = p ^ c[N-1:0];
    Cout = c[N];
    Pout = &p;
    Gout = gg;
  end

endmodule

// File: rtl/cla_seq_adder.sv
// Slice-serial adder: one 4-bit CLA slice per RUN cycle, handshaked in and out.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operA,
  input  logic [WIDTH-1:0] operB,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] resultOUT,
  output logic             Cout,
  output logic             Overflow
);

  localparam int SLICES = WIDTH / SLICE_W;
  localparam int CNT_W  = $clog2(SLICES);
  localparam int SEL_W  = $clog2(SLICE_W);
  localparam int BASE_W = CNT_W + SEL_W;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(SLICES - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  logic [BASE_W-1:0]  w_base;
  logic [SLICE_W-1:0] w_a_slice;
  logic [SLICE_W-1:0] w_b_slice;
  logic [SLICE_W-1:0] w_sum;
  logic               w_cout;
  logic               w_pout_unused;
  logic               w_gout_unused;

  // Bit offset of the slice being worked on this cycle.
  assign w_base    = {r_cnt, {SEL_W{1'b0}}};
  assign w_a_slice = r_a[w_base +: SLICE_W];
  assign w_b_slice = r_b[w_base +: SLICE_W];

  CLA4 #(
    .N (SLICE_W)
  ) u_cla4 (
    .A    (w_a_slice),
    .B    (w_b_slice),
    .Cin  (r_carry),
    .Sum  (w_sum),
    .Cout (w_cout),
    .Pout (w_pout_unused),
    .Gout (w_gout_unused)
  );

  // NOTE: default first so every path assigns w_next_state and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid && in_ready) w_next_state = RUN;
      RUN:     if (r_cnt == LAST_SLICE)  w_next_state = DONE;
      DONE:    if (out_ready)            w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    resultOUT = r_result;
    Cout      = r_carry;
    Overflow  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (r_result[WIDTH-1] != r_a[WIDTH-1]);
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_a     <= operA;
            r_b     <= operB;
            r_carry <= Cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_result[w_base +: SLICE_W] <= w_sum;
          r_carry                     <= w_cout;
          // Counter parks on the last slice; the next acceptance clears it.
          if (r_cnt != LAST_SLICE) r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Randomized and directed bench for cla_seq_adder against an arithmetic reference model.
module tb_cla_seq_adder;

  localparam int WIDTH  = 32;
  localparam int SLICES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] operA = '0;
  logic [WIDTH-1:0] operB = '0;
  logic             Cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] resultOUT;
  logic             Cout;
  logic             Overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  // Directed vectors: operands, carry-in and the hand-derived expected outputs.
  logic [WIDTH-1:0] da [4] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h12345678};
  logic [WIDTH-1:0] db [4] = '{32'h00000001, 32'h00000001, 32'h80000000, 32'h11111111};
  logic             dc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [WIDTH-1:0] ds [4] = '{32'h00000000, 32'h80000000, 32'h00000000, 32'h2345678A};
  logic             dco[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic             dov[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  cla_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operA     (operA),
    .operB     (operB),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .resultOUT (resultOUT),
    .Cout      (Cout),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Unsigned sum for result/carry, signed sum for overflow.
  function automatic exp_t ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic c);
    exp_t          e;
    logic [WIDTH:0] full;
    longint        s;
    longint        lim;
    full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    s      = longint'(signed'(a)) + longint'(signed'(b)) + longint'(c);
    lim    = longint'(1) << (WIDTH - 1);
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.ovf  = (s >= lim) || (s < -lim);
    return e;
  endfunction

  // Present a request, wait for acceptance, then scramble the inputs.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, output int acc);
    int n = 0;
    @(negedge clk);
    operA = a; operB = b; Cin = c; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
    operA = $urandom; operB = $urandom; Cin = 1'($urandom_range(0, 1));
  endtask

  // Wait for out_valid; report cycles since the acceptance edge.
  task automatic wait_done(input int acc, output int lat);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL done_timeout: out_valid=%b required 1", out_valid);
    else pass_cnt++;
    lat = cyc - acc;
  endtask

  task automatic test_reset();
    #2;
    total_cnt++;
    if ({in_ready, out_valid, Cout, Overflow, resultOUT} !== {1'b1, 1'b0, 1'b0, 1'b0, {WIDTH{1'b0}}})
      $display("FAIL reset_state: rdy=%b vld=%b co=%b ov=%b res=%h required 1 0 0 0 0",
               in_ready, out_valid, Cout, Overflow, resultOUT);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int acc, lat;
    for (int i = 0; i < 4; i++) begin
      start_op(da[i], db[i], dc[i], acc);
      wait_done(acc, lat);
      total_cnt++;
      if ({resultOUT, Cout, Overflow} !== {ds[i], dco[i], dov[i]})
        $display("FAIL directed_%0d: res=%h co=%b ov=%b required res=%h co=%b ov=%b",
                 i, resultOUT, Cout, Overflow, ds[i], dco[i], dov[i]);
      else pass_cnt++;
      total_cnt++;
      if (lat !== SLICES) $display("FAIL directed_latency_%0d: %0d cycles required %0d", i, lat, SLICES);
      else pass_cnt++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total_cnt++;
      if ({in_ready, out_valid} !== 2'b10)
        $display("FAIL directed_return_idle_%0d: rdy=%b vld=%b required 1 0", i, in_ready, out_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int acc, lat;
    logic [WIDTH-1:0] a, b;
    logic c;
    exp_t e;
    a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
    e = ref_add(a, b, c);
    start_op(a, b, c, acc);
    wait_done(acc, lat);
    in_valid = 1'b1;
    operA = ~a; operB = ~b; Cin = ~c;
    for (int k = 0; k < 5; k++) begin
      total_cnt++;
      if ({out_valid, in_ready, Cout, Overflow, resultOUT} !== {1'b1, 1'b0, e.cout, e.ovf, e.sum})
        $display("FAIL backpressure_hold_%0d: vld=%b rdy=%b co=%b ov=%b res=%h required 1 0 %b %b %h",
                 k, out_valid, in_ready, Cout, Overflow, resultOUT, e.cout, e.ovf, e.sum);
      else pass_cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total_cnt++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL backpressure_release: rdy=%b vld=%b required 1 0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int acc, lat;
    start_op($urandom, $urandom, 1'b1, acc);
    do @(negedge clk); while (cyc < acc + 3);
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({in_ready, out_valid, Cout, Overflow, resultOUT} !== {1'b1, 1'b0, 1'b0, 1'b0, {WIDTH{1'b0}}})
      $display("FAIL midrun_reset_state: rdy=%b vld=%b co=%b ov=%b res=%h required 1 0 0 0 0",
               in_ready, out_valid, Cout, Overflow, resultOUT);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    operA = 32'h1; operB = 32'h2; Cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL first_edge_accept: rdy=%b required 0", in_ready);
    else pass_cnt++;
    // A surviving pre-reset operation would finish earlier than SLICES cycles from here.
    wait_done(acc, lat);
    total_cnt++;
    if (lat !== SLICES) $display("FAIL midrun_latency: %0d cycles required %0d", lat, SLICES);
    else pass_cnt++;
    total_cnt++;
    if ({resultOUT, Cout, Overflow} !== {32'h00000003, 1'b0, 1'b0})
      $display("FAIL midrun_next_result: res=%h co=%b ov=%b required 00000003 0 0",
               resultOUT, Cout, Overflow);
    else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc, prev_acc, lat, n;
    logic [WIDTH-1:0] a, b;
    logic c;
    exp_t e;
    prev_acc  = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
      if (i == 0) a = 32'hFFFFFFFF;
      e = ref_add(a, b, c);
      @(negedge clk);
      operA = a; operB = b; Cin = c; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      // in_valid stays high with junk operands; it must be ignored until IDLE.
      operA = $urandom; operB = $urandom; Cin = 1'($urandom_range(0, 1));
      if (i > 0) begin
        total_cnt++;
        if (acc - prev_acc !== SLICES + 2)
          $display("FAIL b2b_interval_%0d: %0d cycles required %0d", i, acc - prev_acc, SLICES + 2);
        else pass_cnt++;
      end
      prev_acc = acc;
      wait_done(acc, lat);
      total_cnt++;
      if ({resultOUT, Cout, Overflow} !== {e.sum, e.cout, e.ovf})
        $display("FAIL b2b_result_%0d: res=%h co=%b ov=%b required res=%h co=%b ov=%b",
                 i, resultOUT, Cout, Overflow, e.sum, e.cout, e.ovf);
      else pass_cnt++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
